// File: rtl/adler32_chk.sv
// Adler-32 checker for the inflated zlib payload: folds one byte per cycle
// into s1/s2 (mod 65521) and compares the result with the 4-byte trailer.
module adler32_chk #(
   parameter int          DATA_WD    = 32,
   parameter logic [31:0] ADLER_INIT = 32'h0000_0001,
   parameter int          ADLER_MOD  = 65521
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start_i,
   input  logic               val_i,
   input  logic [DATA_WD-1:0] dat_i,
   input  logic               lst_i,
   input  logic [1:0]         num_i,
   output logic               rdy_o,
   input  logic               chk_val_i,
   input  logic [31:0]        chk_dat_i,
   output logic               chk_rdy_o,
   output logic               done_o,
   output logic               pass_o,
   output logic               err_o,
   output logic [31:0]        dat_o,
   output logic [2:0]         state_o
);

   // Handshake: a payload word moves on a cycle where val_i && rdy_o; a
   // trailer word moves on a cycle where chk_val_i && chk_rdy_o. Valid held
   // while ready is low is not a transfer and the source keeps its data.

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] ACTV = 3'd1;
   localparam logic [2:0] BYTE = 3'd2;
   localparam logic [2:0] WCHK = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   localparam logic [16:0] MOD17  = 17'(ADLER_MOD);
   localparam logic [17:0] MOD18  = 18'(ADLER_MOD);
   localparam logic [17:0] MOD2X  = 18'(2 * ADLER_MOD);

   logic [2:0]  state_q, state_d;
   logic [15:0] s1_q, s1_d;
   logic [15:0] s2_q, s2_d;
   logic [23:0] buf_q, buf_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        last_q, last_d;
   logic        pass_q, pass_d;
   logic        err_q, err_d;

   logic [7:0]  byte_sel;
   logic [31:0] fold_res;
   logic [1:0]  rem_cnt;

   // One byte step; s2 can never exceed 2*(MOD-1), so a single conditional
   // subtraction per accumulator keeps both in [0, MOD-1].
   function automatic logic [31:0] fold_byte(input logic [15:0] s1,
                                             input logic [15:0] s2,
                                             input logic [7:0]  b);
      logic [16:0] a1;
      logic [17:0] a2;
      logic [15:0] s1n;
      logic [15:0] s2n;
      a1 = {1'b0, s1} + {9'd0, b};
      s1n = (a1 >= MOD17) ? 16'(a1 - MOD17) : a1[15:0];
      a2 = {2'b00, s2} + {2'b00, s1n};
      if (a2 >= MOD2X) begin
         s2n = 16'(a2 - MOD2X);
      end else if (a2 >= MOD18) begin
         s2n = 16'(a2 - MOD18);
      end else begin
         s2n = a2[15:0];
      end
      return {s2n, s1n};
   endfunction

   always_comb begin
      byte_sel = (state_q == ACTV) ? dat_i[31:24] : buf_q[23:16];
      fold_res = fold_byte(s1_q, s2_q, byte_sel);
      rem_cnt  = (lst_i && (num_i != 2'd0)) ? (num_i - 2'd1) : 2'd3;
   end

   always_comb begin
      state_d = state_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      pass_d  = pass_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               s1_d    = ADLER_INIT[15:0];
               s2_d    = ADLER_INIT[31:16];
               pass_d  = 1'b0;
               err_d   = 1'b0;
               state_d = ACTV;
            end
         end
         ACTV: begin
            if (val_i) begin
               s1_d   = fold_res[15:0];
               s2_d   = fold_res[31:16];
               buf_d  = dat_i[23:0];
               cnt_d  = rem_cnt;
               last_d = lst_i;
               state_d = (rem_cnt == 2'd0) ? WCHK : BYTE;
            end
         end
         BYTE: begin
            s1_d  = fold_res[15:0];
            s2_d  = fold_res[31:16];
            buf_d = {buf_q[15:0], 8'h00};
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
               state_d = last_q ? WCHK : ACTV;
            end
         end
         WCHK: begin
            if (chk_val_i) begin
               pass_d  = (chk_dat_i == {s2_q, s1_q});
               err_d   = (chk_dat_i != {s2_q, s1_q});
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         s1_q    <= 16'd0;
         s2_q    <= 16'd0;
         buf_q   <= 24'd0;
         cnt_q   <= 2'd0;
         last_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
      end
   end

   assign rdy_o     = (state_q == ACTV);
   assign chk_rdy_o = (state_q == WCHK);
   assign done_o    = (state_q == DONE);
   assign pass_o    = pass_q;
   assign err_o     = err_q;
   assign dat_o     = {s2_q, s1_q};
   assign state_o   = state_q;

endmodule

// File: tb/tb_adler32_chk.sv
// Directed bench for adler32_chk: known Adler-32 vectors, modulo wrap,
// mismatch, ignored start/trailer, and asynchronous reset mid-stream.
module tb_adler32_chk;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ACTV = 3'd1;
   localparam logic [2:0] S_BYTE = 3'd2;
   localparam logic [2:0] S_WCHK = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start_i;
   logic        val_i;
   logic [31:0] dat_i;
   logic        lst_i;
   logic [1:0]  num_i;
   logic        rdy_o;
   logic        chk_val_i;
   logic [31:0] chk_dat_i;
   logic        chk_rdy_o;
   logic        done_o;
   logic        pass_o;
   logic        err_o;
   logic [31:0] dat_o;
   logic [2:0]  state_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   adler32_chk dut (
      .clk       (clk),
      .rstn      (rstn),
      .start_i   (start_i),
      .val_i     (val_i),
      .dat_i     (dat_i),
      .lst_i     (lst_i),
      .num_i     (num_i),
      .rdy_o     (rdy_o),
      .chk_val_i (chk_val_i),
      .chk_dat_i (chk_dat_i),
      .chk_rdy_o (chk_rdy_o),
      .done_o    (done_o),
      .pass_o    (pass_o),
      .err_o     (err_o),
      .dat_o     (dat_o),
      .state_o   (state_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      n_cmp++;
      n_err++;
      $error("FAIL %s: timeout waiting for ready", tag);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_stream();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      check("start_state", 32'(state_o), 32'(S_ACTV));
      check("start_load", dat_o, 32'h0000_0001);
      check("start_clear", {30'd0, pass_o, err_o}, 32'd0);
   endtask

   task automatic send_word(input logic [31:0] d, input logic l, input logic [1:0] n);
      int k;
      val_i = 1'b1;
      dat_i = d;
      lst_i = l;
      num_i = n;
      k = 0;
      while (!rdy_o && k < 16) begin
         step();
         k++;
      end
      if (!rdy_o) timeout("send_word");
      else step();
      val_i = 1'b0;
      lst_i = 1'b0;
      num_i = 2'd0;
   endtask

   task automatic send_chk(input logic [31:0] c);
      int k;
      chk_val_i = 1'b1;
      chk_dat_i = c;
      k = 0;
      while (!chk_rdy_o && k < 16) begin
         step();
         k++;
      end
      if (!chk_rdy_o) timeout("send_chk");
      else step();
      chk_val_i = 1'b0;
   endtask

   initial begin
      rstn      = 1'b0;
      start_i   = 1'b0;
      val_i     = 1'b0;
      dat_i     = 32'd0;
      lst_i     = 1'b0;
      num_i     = 2'd0;
      chk_val_i = 1'b0;
      chk_dat_i = 32'd0;
      repeat (3) step();
      check("rst_state", 32'(state_o), 32'(S_IDLE));
      check("rst_flags", {26'd0, rdy_o, chk_rdy_o, done_o, pass_o, err_o, 1'b0}, 32'd0);
      check("rst_dat", dat_o, 32'd0);
      rstn = 1'b1;
      step();
      check("idle_hold", 32'(state_o), 32'(S_IDLE));

      // "a"
      start_stream();
      send_word(32'h6100_0000, 1'b1, 2'd1);
      check("a_state", 32'(state_o), 32'(S_WCHK));
      check("a_dat", dat_o, 32'h0062_0062);
      send_chk(32'h0062_0062);
      check("a_done", {31'd0, done_o}, 32'd1);
      check("a_pass", {30'd0, pass_o, err_o}, 32'b10);
      step();
      check("a_done_off", {31'd0, done_o}, 32'd0);
      check("a_idle", 32'(state_o), 32'(S_IDLE));
      check("a_pass_hold", {31'd0, pass_o}, 32'd1);
      check("a_dat_hold", dat_o, 32'h0062_0062);

      // "abc": two BYTE cycles after the transfer
      start_stream();
      send_word(32'h6162_6300, 1'b1, 2'd3);
      check("abc_byte1", 32'(state_o), 32'(S_BYTE));
      check("abc_rdy1", {31'd0, rdy_o}, 32'd0);
      step();
      check("abc_byte2", 32'(state_o), 32'(S_BYTE));
      step();
      check("abc_wchk", 32'(state_o), 32'(S_WCHK));
      check("abc_chk_rdy", {31'd0, chk_rdy_o}, 32'd1);
      check("abc_dat", dat_o, 32'h024D_0127);
      send_chk(32'h024D_0127);
      check("abc_done", {31'd0, done_o}, 32'd1);
      check("abc_pass", {30'd0, pass_o, err_o}, 32'b10);
      step();

      // "Wikipedia" with start_i asserted mid-stream
      start_stream();
      send_word(32'h5769_6B69, 1'b0, 2'd0);
      check("wk_rdy_b1", {31'd0, rdy_o}, 32'd0);
      start_i = 1'b1;
      step();
      check("wk_rdy_b2", {31'd0, rdy_o}, 32'd0);
      step();
      check("wk_rdy_b3", {31'd0, rdy_o}, 32'd0);
      start_i = 1'b0;
      step();
      check("wk_rdy_back", {31'd0, rdy_o}, 32'd1);
      send_word(32'h7065_6469, 1'b0, 2'd0);
      send_word(32'h6100_0000, 1'b1, 2'd1);
      check("wk_wchk", 32'(state_o), 32'(S_WCHK));
      check("wk_dat", dat_o, 32'h11E6_0398);
      send_chk(32'h11E6_0398);
      check("wk_done", {31'd0, done_o}, 32'd1);
      check("wk_pass", {30'd0, pass_o, err_o}, 32'b10);
      step();

      // "abc" mismatch, trailer offered early while still in BYTE
      start_stream();
      send_word(32'h6162_6300, 1'b1, 2'd3);
      chk_val_i = 1'b1;
      chk_dat_i = 32'h024D_0128;
      check("early_chk_rdy", {31'd0, chk_rdy_o}, 32'd0);
      step();
      check("early_chk_state", 32'(state_o), 32'(S_BYTE));
      check("early_chk_done", {31'd0, done_o}, 32'd0);
      send_chk(32'h024D_0128);
      check("mm_done", {31'd0, done_o}, 32'd1);
      check("mm_err", {30'd0, pass_o, err_o}, 32'b01);
      step();
      check("mm_err_hold", {30'd0, pass_o, err_o}, 32'b01);

      // Modulo wrap: 4096 bytes of 0xFF
      start_stream();
      for (int i = 0; i < 1024; i++) begin
         send_word(32'hFFFF_FFFF, (i == 1023), 2'd0);
         check("wrap_s1_rng", {31'd0, (dat_o[15:0] <= 16'd65520)}, 32'd1);
         check("wrap_s2_rng", {31'd0, (dat_o[31:16] <= 16'd65520)}, 32'd1);
      end
      send_chk(32'h8161_F0E2);
      check("wrap_dat", dat_o, 32'h8161_F0E2);
      check("wrap_pass", {30'd0, pass_o, err_o}, 32'b10);
      step();

      // Reset pulsed during BYTE
      start_stream();
      send_word(32'hFFFF_FFFF, 1'b0, 2'd0);
      check("rb_byte", 32'(state_o), 32'(S_BYTE));
      rstn = 1'b0;
      #1;
      check("rb_state", 32'(state_o), 32'(S_IDLE));
      check("rb_flags", {27'd0, rdy_o, chk_rdy_o, done_o, pass_o, err_o}, 32'd0);
      check("rb_dat", dat_o, 32'd0);
      step();
      rstn = 1'b1;
      step();
      check("rb_after_state", 32'(state_o), 32'(S_IDLE));
      check("rb_after_done", {31'd0, done_o}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
